// File: rtl/linear_proj_pkg.sv
// Shared constants and types for the linear-projection C-buffer path.
// Default tile geometry, derived widths, the reader FSM state type and a
// counter-width helper. Pure package, no ports.
package linear_proj_pkg;

  // Counter/address width that never collapses below one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned C_WIDTH_OUT   = 16;
  localparam int unsigned TILE_ROWS     = 8;
  localparam int unsigned TILE_COLS     = 8;
  localparam int unsigned C_ROW_TILES   = 1;
  localparam int unsigned C_COL_TILES   = 1;
  localparam int unsigned C_TILE_W      = TILE_ROWS * TILE_COLS * C_WIDTH_OUT;
  localparam int unsigned C_ROW_W       = TILE_COLS * C_WIDTH_OUT;
  localparam int unsigned C_ADDR_W      = cnt_w(C_ROW_TILES * C_COL_TILES);
  localparam int unsigned C_TOTAL_BEATS = C_ROW_TILES * TILE_ROWS * C_COL_TILES;

  typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_DRAIN} c_rd_state_e;

endpackage

// File: rtl/linear_proj_skid_fifo.sv
// Two-entry output FIFO with the head held in a register.
// Ports: clk, rst (sync, active high), push/push_data, pop, head (entry at
// the front), count (0..2), valid (count != 0).
// The second entry is kept at zero whenever it is unused, so head reads
// zero once the FIFO empties.
module linear_proj_skid_fifo #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         valid
);

  logic [W-1:0] tail;

  assign valid = (count != 2'd0);

  // Shift-style storage: pops move tail into head.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          count <= count + 2'd1;
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
        end
        2'b01: begin
          count <= count - 2'd1;
          head  <= tail;
          tail  <= '0;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/linear_proj_c_reader.sv
// Drain side of the linear-projection C buffer: reads C tiles back and
// streams the C matrix row-major, one tile row per valid/ready beat.
// Ports: clk, rst (sync, active high), start/busy/done control,
// c_rd_en/c_rd_addr/c_rd_data buffer read port (data one cycle after enable),
// out_valid/out_ready/out_data/out_last result stream.
// Option LINEAR_PROJ_C_READER_ROW_LAST_EN adds out_row_last, marking the
// final beat of every C row.
module linear_proj_c_reader #(
  parameter int unsigned WIDTH_OUT = linear_proj_pkg::C_WIDTH_OUT,
  parameter int unsigned TILE_ROWS = linear_proj_pkg::TILE_ROWS,
  parameter int unsigned TILE_COLS = linear_proj_pkg::TILE_COLS,
  parameter int unsigned ROW_TILES = linear_proj_pkg::C_ROW_TILES,
  parameter int unsigned COL_TILES = linear_proj_pkg::C_COL_TILES,
  parameter int unsigned ADDR_W    = linear_proj_pkg::cnt_w(ROW_TILES * COL_TILES)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 c_rd_en,
  output logic [ADDR_W-1:0]                    c_rd_addr,
  input  logic [TILE_ROWS*TILE_COLS*WIDTH_OUT-1:0] c_rd_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [TILE_COLS*WIDTH_OUT-1:0]       out_data,
  output logic                                 out_last
`ifdef LINEAR_PROJ_C_READER_ROW_LAST_EN
  ,
  output logic                                 out_row_last
`endif
);

  import linear_proj_pkg::*;

  localparam int unsigned ROW_W = TILE_COLS * WIDTH_OUT;
  localparam int unsigned CW    = cnt_w(COL_TILES);
  localparam int unsigned IW    = cnt_w(TILE_ROWS);
  localparam int unsigned RW    = cnt_w(ROW_TILES);
`ifdef LINEAR_PROJ_C_READER_ROW_LAST_EN
  localparam int unsigned EW    = ROW_W + 2;
`else
  localparam int unsigned EW    = ROW_W + 1;
`endif

  c_rd_state_e   state;
  logic [CW-1:0] col_q;
  logic [IW-1:0] row_q;
  logic [RW-1:0] tile_row_q;
  logic          inflight_q;
  logic [IW-1:0] rd_i_q;
  logic          rd_last_q;
  logic          col_last, row_last, tile_row_last, issue_last;
  logic          pop;
  logic [1:0]    fifo_count;
  logic [2:0]    occ;
  logic [ROW_W-1:0] sel_row;
  logic [EW-1:0] push_data, head;

  assign col_last      = (col_q == CW'(COL_TILES - 1));
  assign row_last      = (row_q == IW'(TILE_ROWS - 1));
  assign tile_row_last = (tile_row_q == RW'(ROW_TILES - 1));
  assign issue_last    = col_last && row_last && tile_row_last;

  // Credit check includes this cycle's pop so a full-rate stream never
  // bubbles; c_rd_en is therefore a direct function of out_ready.
  assign pop     = out_valid && out_ready;
  assign occ     = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign c_rd_en = (state == RD_RUN) && (occ < 3'd2);

  assign c_rd_addr = ADDR_W'(32'(tile_row_q) * COL_TILES + 32'(col_q));

  // Pick the tile row that matches the read issued last cycle.
  assign sel_row = c_rd_data[32'(rd_i_q) * ROW_W +: ROW_W];

`ifdef LINEAR_PROJ_C_READER_ROW_LAST_EN
  logic rd_row_last_q;
  assign push_data    = {rd_row_last_q, rd_last_q, sel_row};
  assign out_row_last = head[ROW_W+1];
`else
  assign push_data    = {rd_last_q, sel_row};
`endif
  assign out_data = head[ROW_W-1:0];
  assign out_last = head[ROW_W];

  // Control FSM, tile/row counters and the one-cycle read side-band pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RD_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      tile_row_q <= '0;
      inflight_q <= 1'b0;
      rd_i_q     <= '0;
      rd_last_q  <= 1'b0;
`ifdef LINEAR_PROJ_C_READER_ROW_LAST_EN
      rd_row_last_q <= 1'b0;
`endif
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      inflight_q <= c_rd_en;
      rd_i_q     <= row_q;
      rd_last_q  <= issue_last;
`ifdef LINEAR_PROJ_C_READER_ROW_LAST_EN
      rd_row_last_q <= col_last;
`endif
      case (state)
        RD_IDLE: begin
          if (start) begin
            state <= RD_RUN;
            busy  <= 1'b1;
          end
        end
        RD_RUN: begin
          if (c_rd_en) begin
            if (col_last) begin
              col_q <= '0;
              if (row_last) begin
                row_q      <= '0;
                tile_row_q <= tile_row_last ? '0 : tile_row_q + RW'(1);
              end else begin
                row_q <= row_q + IW'(1);
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
            if (issue_last) state <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          // Finish on the cycle the FIFO goes empty with nothing returning.
          if ((fifo_count == 2'(pop)) && !inflight_q) begin
            state <= RD_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  linear_proj_skid_fifo #(.W(EW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .valid     (out_valid)
  );

endmodule

// File: tb/tb_linear_proj_c_reader.sv
`timescale 1ns/1ps
module tb_linear_proj_c_reader;

  localparam int TR  = 8;
  localparam int TC  = 8;
  localparam int W   = 16;
  localparam int RWD = TC * W;
  localparam int TW  = TR * TC * W;

  typedef struct packed {
    logic [RWD-1:0] data;
    logic           last;
    logic           row_last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst [2];
  logic           start [2];
  logic           ready [2];
  logic           busy [2];
  logic           done [2];
  logic           rd_en [2];
  logic           out_valid [2];
  logic           out_last [2];
`ifdef LINEAR_PROJ_C_READER_ROW_LAST_EN
  logic           row_last [2];
`endif
  logic [0:0]     addr0;
  logic [1:0]     addr1;
  logic [1:0]     rd_addr [2];
  logic [TW-1:0]  rd_data [2];
  logic [RWD-1:0] out_data [2];
  logic [15:0]    salt [2];
  int             mode [2];
  int             reads [2];
  int             beats [2];
  int             dones [2];
  int             done_cyc [2];
  int             start_cyc [2];
  logic           hold_v [2];
  logic [RWD-1:0] hold_d [2];
  beat_t          exp_q [2][$];
  int             addr_q [2][$];
  int             cyc = 0;
  int             total = 0;
  int             bad = 0;

  linear_proj_c_reader u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .c_rd_en(rd_en[0]), .c_rd_addr(addr0), .c_rd_data(rd_data[0]),
    .out_valid(out_valid[0]), .out_ready(ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0])
`ifdef LINEAR_PROJ_C_READER_ROW_LAST_EN
    , .out_row_last(row_last[0])
`endif
  );

  linear_proj_c_reader #(.ROW_TILES(2), .COL_TILES(2)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .c_rd_en(rd_en[1]), .c_rd_addr(addr1), .c_rd_data(rd_data[1]),
    .out_valid(out_valid[1]), .out_ready(ready[1]), .out_data(out_data[1]),
    .out_last(out_last[1])
`ifdef LINEAR_PROJ_C_READER_ROW_LAST_EN
    , .out_row_last(row_last[1])
`endif
  );

  assign rd_addr[0] = {1'b0, addr0};
  assign rd_addr[1] = addr1;

  task automatic chk(input string name, input logic [RWD-1:0] act, input logic [RWD-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] elem(input int k, input int i, input int j, input logic [15:0] s);
    return 16'(k * 256 + i * 8 + j) ^ s;
  endfunction

  // Buffer contents: tile k holds elem(k,i,j) at flat index i*TC+j.
  function automatic logic [TW-1:0] tile_word(input int k, input logic [15:0] s);
    logic [TW-1:0] w;
    for (int i = 0; i < TR; i++)
      for (int j = 0; j < TC; j++)
        w[(i * TC + j) * W +: W] = elem(k, i, j, s);
    return w;
  endfunction

  // Expected stream: for r, for i, for c -> row i of tile r*n+c.
  task automatic expect_run(input int d);
    int n;
    n = (d == 0) ? 1 : 2;
    for (int r = 0; r < n; r++)
      for (int i = 0; i < TR; i++)
        for (int c = 0; c < n; c++) begin
          beat_t b;
          for (int j = 0; j < TC; j++) b.data[j * W +: W] = elem(r * n + c, i, j, salt[d]);
          b.last     = (r == n - 1) && (i == TR - 1) && (c == n - 1);
          b.row_last = (c == n - 1);
          exp_q[d].push_back(b);
          addr_q[d].push_back(r * n + c);
        end
  endtask

  // Buffer model: data one cycle after enable, garbage otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++)
      if (rd_en[d]) rd_data[d] <= tile_word(int'(rd_addr[d]), salt[d]);
      else          rd_data[d] <= {32{32'($urandom)}};
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
        case (mode[d])
          0:       ready[d] = 1'b1;
          1:       ready[d] = 1'($urandom_range(0, 1));
          default: ready[d] = 1'b0;
        endcase
    end
  end

  // Monitor: address checks, beat scoreboard, stall stability, occupancy.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      beat_t e;
      if (!rst[d]) begin
        if (done[d]) begin
          dones[d]++;
          done_cyc[d] = cyc;
        end
        if (rd_en[d]) begin
          reads[d]++;
          if (addr_q[d].size() == 0) begin
            total++; bad++;
            $display("FAIL rd_extra: dut%0d read addr %0d with none expected", d, rd_addr[d]);
          end else begin
            chk("rd_addr", RWD'(rd_addr[d]), RWD'(addr_q[d].pop_front()));
          end
        end
        if (hold_v[d]) begin
          chk("stall_valid", RWD'(out_valid[d]), RWD'(1));
          chk("stall_data", out_data[d], hold_d[d]);
        end
        if (out_valid[d] && ready[d]) begin
          beats[d]++;
          if (exp_q[d].size() == 0) begin
            total++; bad++;
            $display("FAIL beat_extra: dut%0d beat %h with none expected", d, out_data[d]);
          end else begin
            e = exp_q[d].pop_front();
            chk("beat_data", out_data[d], e.data);
            chk("beat_last", RWD'(out_last[d]), RWD'(e.last));
`ifdef LINEAR_PROJ_C_READER_ROW_LAST_EN
            chk("beat_row_last", RWD'(row_last[d]), RWD'(e.row_last));
`endif
          end
        end
        if (rd_en[d]) chk("occupancy_le2", RWD'(reads[d] - beats[d] <= 2), RWD'(1));
        hold_v[d] = out_valid[d] && !ready[d];
        hold_d[d] = out_data[d];
      end
    end
  end

  // Called #1 after a clock edge; returns #1 after the edge that took start.
  task automatic go(input int d);
    salt[d]  = 16'($urandom);
    reads[d] = 0;
    beats[d] = 0;
    expect_run(d);
    start[d]     = 1'b1;
    start_cyc[d] = cyc;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    chk("busy_after_start", RWD'(busy[d]), RWD'(1));
  endtask

  task automatic wait_done(input int d, input int lat);
    int d0;
    d0 = dones[d];
    for (int k = 0; k < 3000 && dones[d] == d0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("done_seen", RWD'(dones[d] - d0), RWD'(1));
    if (lat >= 0) chk("done_latency", RWD'(done_cyc[d] - start_cyc[d]), RWD'(lat));
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("done_single", RWD'(dones[d] - d0), RWD'(1));
    chk("beats_left", RWD'(exp_q[d].size()), '0);
    chk("reads_left", RWD'(addr_q[d].size()), '0);
    chk("busy_idle", RWD'(busy[d]), '0);
  endtask

  task automatic chk_idle(input int d);
    chk("rst_busy", RWD'(busy[d]), '0);
    chk("rst_done", RWD'(done[d]), '0);
    chk("rst_rd_en", RWD'(rd_en[d]), '0);
    chk("rst_valid", RWD'(out_valid[d]), '0);
    chk("rst_last", RWD'(out_last[d]), '0);
    chk("rst_addr", RWD'(rd_addr[d]), '0);
    chk("rst_data", out_data[d], '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; ready[d] = 1'b1; mode[d] = 0;
      reads[d] = 0; beats[d] = 0; dones[d] = 0; hold_v[d] = 1'b0;
      salt[d] = 16'h0; done_cyc[d] = 0; start_cyc[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk_idle(d);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk);
    #1;

    // Default geometry, full rate.
    go(0);
    wait_done(0, 11);
    chk("t1_beats", RWD'(beats[0]), RWD'(8));

    // 2x2 tiles, full rate.
    go(1);
    wait_done(1, 35);
    chk("t2_beats", RWD'(beats[1]), RWD'(32));

    // 2x2 tiles, random backpressure.
    mode[1] = 1;
    go(1);
    wait_done(1, -1);
    chk("t3_beats", RWD'(beats[1]), RWD'(32));
    mode[1] = 0;

    // Held backpressure: only two reads may be outstanding.
    mode[1] = 2;
    go(1);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("t4_reads", RWD'(reads[1]), RWD'(2));
    chk("t4_beats", RWD'(beats[1]), '0);
    chk("t4_valid", RWD'(out_valid[1]), RWD'(1));
    mode[1] = 0;
    wait_done(1, -1);
    chk("t4_beats_end", RWD'(beats[1]), RWD'(32));

    // Reset mid-stream, then a clean run.
    go(0);
    for (int k = 0; k < 200 && beats[0] < 5; k++) begin
      @(posedge clk);
      #1;
    end
    chk("t5_reach_beat5", RWD'(beats[0] >= 5), RWD'(1));
    rst[0] = 1'b1;
    exp_q[0].delete();
    addr_q[0].delete();
    hold_v[0] = 1'b0;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    chk_idle(0);
    go(0);
    wait_done(0, 11);
    chk("t5_beats", RWD'(beats[0]), RWD'(8));

    // Start re-pulsed while busy is ignored.
    go(0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_done(0, 11);
    chk("t6_beats", RWD'(beats[0]), RWD'(8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
